// File: rtl/audio_pkg.sv
// Shared widths and limits for the TIA audio mixer path feeding the PWM controller.
package audio_pkg;
  localparam int CW_W       = 10;
  localparam int FRAME_LOG2 = 10;
  localparam int SAMPLE_W   = 5;
  localparam int SUM_W      = 15;
  localparam int CW_MAX     = 960;

  typedef logic [CW_W-1:0]     cw_t;
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [SUM_W-1:0]    sum_t;
endpackage

// File: rtl/pwm_slew_limiter.sv
// Combinational slew limiter: moves cur toward tgt by at most MAX_STEP per update.
module pwm_slew_limiter
  import audio_pkg::*;
#(
  parameter int MAX_STEP = 64
) (
  input  logic [CW_W-1:0] cur,
  input  logic [CW_W-1:0] tgt,
  output logic [CW_W-1:0] nxt
);
  typedef logic signed [CW_W+1:0] wide_t;

  localparam wide_t STEP = wide_t'(MAX_STEP);

  wide_t d;
  wide_t up;
  wide_t dn;

  function automatic logic [CW_W-1:0] sat_cw(input wide_t v);
    if (v < 0)
      return '0;
    else if (v > wide_t'(CW_MAX))
      return CW_W'(CW_MAX);
    else
      return v[CW_W-1:0];
  endfunction

  always_comb begin
    d   = $signed({2'b00, tgt}) - $signed({2'b00, cur});
    up  = $signed({2'b00, cur}) + STEP;
    dn  = $signed({2'b00, cur}) - STEP;
    nxt = tgt;
    if (MAX_STEP != 0 && (d > STEP || d < -STEP)) begin
      if (d > 0)
        nxt = sat_cw(up);
      else
        nxt = sat_cw(dn);
    end
  end
endmodule

// File: rtl/pwm_audio_mixer.sv
// Mixes two volume-gated TIA channel bits, box-filters over a 1024-clock frame,
// slew-limits the frame average and hands it to the PWM stage once per frame.
module pwm_audio_mixer
  import audio_pkg::*;
#(
  parameter int MAX_STEP   = 64,
  parameter int FRAME_LOG2 = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ch0_bit,
  input  logic [3:0]      ch0_vol,
  input  logic            ch1_bit,
  input  logic [3:0]      ch1_vol,
  input  logic            mute,
  output logic [CW_W-1:0] pwm_cw,
  output logic            cw_valid
);
  logic [FRAME_LOG2-1:0] frame_cnt;
  sample_t               s_p0;
  sum_t                  acc;
  sum_t                  frame_sum;
  logic                  frame_end;
  logic [CW_W-1:0]       target_p1;
  logic                  vld_p1;
  logic [CW_W-1:0]       slew_tgt;
  logic [CW_W-1:0]       slew_nxt;

  // Stage 0: instantaneous mix, summed into the running frame accumulator.
  always_comb begin
    s_p0 = (ch0_bit ? SAMPLE_W'(ch0_vol) : '0) + (ch1_bit ? SAMPLE_W'(ch1_vol) : '0);
  end

  assign frame_sum = acc + SUM_W'(s_p0);
  assign frame_end = &frame_cnt;

  // Stage 1: latched frame average; mute only matters when it is consumed.
  assign slew_tgt = mute ? '0 : target_p1;

  pwm_slew_limiter #(
    .MAX_STEP (MAX_STEP)
  ) u_slew (
    .cur (pwm_cw),
    .tgt (slew_tgt),
    .nxt (slew_nxt)
  );

  // vld_p1 marks the cycle right after the target latch, so the first frame
  // after reset produces no update from the empty pre-reset average.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt <= '0;
      acc       <= '0;
      target_p1 <= '0;
      vld_p1    <= 1'b0;
      pwm_cw    <= '0;
      cw_valid  <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
      vld_p1    <= frame_end;
      cw_valid  <= vld_p1;
      if (frame_end) begin
        target_p1 <= frame_sum[SUM_W-1 -: CW_W];
        acc       <= '0;
      end else begin
        acc       <= frame_sum;
      end
      // Stage 2: registered control word, the only value the PWM stage sees.
      if (vld_p1)
        pwm_cw <= slew_nxt;
    end
  end
endmodule

// File: tb/tb_pwm_audio_mixer.sv
// Scoreboard bench: a limited (MAX_STEP=64) and an unlimited (MAX_STEP=0) mixer
// share stimulus; a frame-level model predicts every cw_valid pulse and value.
module tb_pwm_audio_mixer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       ch0_bit = 1'b0;
  logic [3:0] ch0_vol = 4'd0;
  logic       ch1_bit = 1'b0;
  logic [3:0] ch1_vol = 4'd0;
  logic       mute = 1'b0;
  logic [9:0] cw_lim;
  logic [9:0] cw_raw;
  logic       vld_lim;
  logic       vld_raw;

  always #5 clk = ~clk;

  pwm_audio_mixer #(.MAX_STEP(64), .FRAME_LOG2(10)) u_lim (
    .clk(clk), .reset_n(reset_n),
    .ch0_bit(ch0_bit), .ch0_vol(ch0_vol),
    .ch1_bit(ch1_bit), .ch1_vol(ch1_vol),
    .mute(mute), .pwm_cw(cw_lim), .cw_valid(vld_lim)
  );

  pwm_audio_mixer #(.MAX_STEP(0), .FRAME_LOG2(10)) u_raw (
    .clk(clk), .reset_n(reset_n),
    .ch0_bit(ch0_bit), .ch0_vol(ch0_vol),
    .ch1_bit(ch1_bit), .ch1_vol(ch1_vol),
    .mute(mute), .pwm_cw(cw_raw), .cw_valid(vld_raw)
  );

  typedef struct {
    int at;
    int cw;
  } exp_t;

  exp_t q_lim[$];
  exp_t q_raw[$];
  int   last_cw[2];
  int   n_checks = 0;
  int   n_pass = 0;
  int   edges = 0;
  bit   mon_en = 1'b0;

  int   c = 0;
  int   frame_acc = 0;
  int   model_target = 0;
  int   model_cw[2];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int slew(input int cur, input int t, input int ms);
    int d;
    d = t - cur;
    if (ms == 0 || (d <= ms && d >= -ms)) return t;
    if (d > 0) return cur + ms;
    return cur - ms;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  task automatic check_chan(input int i, input logic v, input int cw);
    exp_t e;
    int   have;
    have = (i == 0) ? q_lim.size() : q_raw.size();
    if (have > 0) e = (i == 0) ? q_lim[0] : q_raw[0];
    if (v) begin
      if (have == 0) begin
        chk(i == 0 ? "lim_unexpected_pulse" : "raw_unexpected_pulse", int'(v), 0);
      end else begin
        if (i == 0) void'(q_lim.pop_front()); else void'(q_raw.pop_front());
        chk(i == 0 ? "lim_pulse_edge" : "raw_pulse_edge", edges, e.at);
        chk(i == 0 ? "lim_cw" : "raw_cw", cw, e.cw);
        last_cw[i] = e.cw;
      end
    end else begin
      if (have > 0 && e.at <= edges) begin
        chk(i == 0 ? "lim_missed_pulse" : "raw_missed_pulse", int'(v), 1);
        if (i == 0) void'(q_lim.pop_front()); else void'(q_raw.pop_front());
        last_cw[i] = e.cw;
      end
      chk(i == 0 ? "lim_hold" : "raw_hold", cw, last_cw[i]);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      check_chan(0, vld_lim, int'(cw_lim));
      check_chan(1, vld_raw, int'(cw_raw));
    end
  end

  // One clock of stimulus; the model follows the frame rules on plain integers.
  task automatic tick(input logic b0, input logic [3:0] v0, input logic b1,
                      input logic [3:0] v1, input logic m);
    int t;
    exp_t e;
    @(negedge clk);
    ch0_bit = b0; ch0_vol = v0; ch1_bit = b1; ch1_vol = v1; mute = m;
    if (c % 1024 == 0 && c > 0) begin
      t = m ? 0 : model_target;
      model_cw[0] = slew(model_cw[0], t, 64);
      model_cw[1] = slew(model_cw[1], t, 0);
      e.at = c + 1;
      e.cw = model_cw[0]; q_lim.push_back(e);
      e.cw = model_cw[1]; q_raw.push_back(e);
    end
    frame_acc += (b0 ? int'(v0) : 0) + (b1 ? int'(v1) : 0);
    if (c % 1024 == 1023) begin
      model_target = frame_acc / 32;
      frame_acc = 0;
    end
    c++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    if (mon_en) begin
      chk("reset_cw_lim", int'(cw_lim), 0);
      chk("reset_cw_raw", int'(cw_raw), 0);
      chk("reset_vld_lim", int'(vld_lim), 0);
      chk("reset_vld_raw", int'(vld_raw), 0);
    end
    q_lim.delete();
    q_raw.delete();
    c = 0; frame_acc = 0; model_target = 0;
    model_cw[0] = 0; model_cw[1] = 0;
    last_cw[0] = 0; last_cw[1] = 0;
    ch0_bit = 1'b0; ch0_vol = 4'd0; ch1_bit = 1'b0; ch1_vol = 4'd0; mute = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic m;
    model_cw[0] = 0; model_cw[1] = 0;
    last_cw[0] = 0; last_cw[1] = 0;
    do_reset();
    repeat (2048) tick(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    repeat (1024) tick(1'b1, 4'd15, 1'b0, 4'd0, 1'b0);
    repeat (1024) tick(1'b1, 4'd15, 1'b1, 4'd15, 1'b0);
    repeat (1524) tick(1'b1, 4'd15, 1'b1, 4'd15, 1'b0);
    do_reset();
    repeat (16 * 1024 + 300) tick(1'b1, 4'd15, 1'b1, 4'd15, 1'b0);
    repeat (16 * 1024 - 300) tick(1'b1, 4'd15, 1'b1, 4'd15, 1'b1);
    repeat (4 * 1024) tick(1'b1, 4'd15, 1'b1, 4'd15, 1'b0);
    for (int k = 0; k < 2048; k++) tick(1'(k % 2), 4'd8, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 2048; k++) tick(1'b1, (k % 1024) < 512 ? 4'd15 : 4'd0, 1'b0, 4'd0, 1'b0);
    m = 1'b0;
    for (int k = 0; k < 6 * 1024; k++) begin
      if ($urandom_range(0, 1499) == 0) m = ~m;
      tick(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), m);
    end
    repeat (1030) tick(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q_lim.size() + q_raw.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
